// File: rtl/patgen_pkg.sv
// Shared types and LFSR definition for the axis_pattern_gen stream source.
package patgen_pkg;

  typedef enum logic [1:0] {
    IDLE_ST = 2'd0,
    LOAD_ST = 2'd1,
    RUN_ST  = 2'd2,
    END_ST  = 2'd3
  } state_t;

  localparam logic [31:0] LFSR_TAPS = 32'h80200003;

  // Right-shifting Galois step: the bit shifted out folds the taps back in.
  function automatic logic [31:0] lfsr_next(input logic [31:0] s);
    return (s >> 1) ^ (s[0] ? LFSR_TAPS : 32'h0);
  endfunction

endpackage

// File: rtl/patgen_lfsr32.sv
// 32-bit Galois LFSR with seed load (zero seed forced to 1) and advance enable.
module patgen_lfsr32
  import patgen_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        load_i,
  input  logic [31:0] seed_i,
  input  logic        adv_i,
  output logic [31:0] state_o
);

  logic [31:0] state_q;
  logic [31:0] state_d;

  always_comb begin
    state_d = state_q;
    if (load_i) begin
      state_d = (seed_i == 32'h0) ? 32'h1 : seed_i;
    end else if (adv_i) begin
      state_d = lfsr_next(state_q);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= 32'h0;
    end else begin
      state_q <= state_d;
    end
  end

  assign state_o = state_q;

endmodule

// File: rtl/axis_pattern_gen.sv
// Deterministic AXI4-Stream source (counter pattern; LFSR pattern when
// PATGEN_LFSR_EN is defined) with a run-duration cycle counter.
module axis_pattern_gen
  import patgen_pkg::*;
#(
  parameter int DATA_WIDTH   = 64,
  parameter int BURST_LENGTH = 7
) (
  input  logic                      clk,
  input  logic                      rst,
  output logic                      m_axis_tvalid,
  input  logic                      m_axis_tready,
  output logic [DATA_WIDTH-1:0]     m_axis_tdata,
  output logic [DATA_WIDTH/8-1:0]   m_axis_tstrb,
  output logic                      m_axis_tlast,
  input  logic                      START_REG,
  input  logic [31:0]               NBURST_REG,
  input  logic [31:0]               SEED_REG,
`ifdef PATGEN_LFSR_EN
  input  logic                      PATTERN_REG,
`endif
  output logic                      IDLE_REG,
  output logic [31:0]               CYCLES_REG
);

  localparam int BEAT_W = (BURST_LENGTH > 0) ? $clog2(BURST_LENGTH + 1) : 1;
  localparam logic [BEAT_W-1:0] BEAT_MAX = BEAT_W'(BURST_LENGTH);

  state_t                  state_q, state_d;
  logic [BEAT_W-1:0]       beat_q, beat_d;
  logic [31:0]             burst_q;
  logic [31:0]             nburst_q;
  logic [31:0]             cycles_q;
  logic [DATA_WIDTH-1:0]   cnt_q;
  logic                    tvalid_q;
  logic                    tlast_q;
  logic                    idle_q;

  logic load_en;
  logic run_en;
  logic accept;
  logic last_accept;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE_ST;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE_ST: if (START_REG) state_d = LOAD_ST;
      LOAD_ST: state_d = (NBURST_REG == 32'h0) ? END_ST : RUN_ST;
      RUN_ST:  if (last_accept) state_d = END_ST;
      END_ST:  if (!START_REG) state_d = IDLE_ST;
      default: state_d = IDLE_ST;
    endcase
  end

  always_comb begin
    load_en     = (state_q == LOAD_ST);
    run_en      = (state_q == RUN_ST);
    accept      = run_en & tvalid_q & m_axis_tready;
    last_accept = accept & tlast_q & (burst_q == (nburst_q - 32'd1));
    beat_d      = beat_q;
    if (load_en) begin
      beat_d = '0;
    end else if (accept) begin
      beat_d = (beat_q == BEAT_MAX) ? '0 : beat_q + BEAT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      beat_q   <= '0;
      burst_q  <= 32'h0;
      nburst_q <= 32'h0;
      cycles_q <= 32'h0;
      cnt_q    <= '0;
      tvalid_q <= 1'b0;
      tlast_q  <= 1'b0;
      idle_q   <= 1'b1;
    end else begin
      beat_q <= beat_d;
      // tvalid/tlast come from next-state so they are registered yet
      // already correct on the first cycle of RUN_ST.
      tvalid_q <= (state_d == RUN_ST);
      tlast_q  <= (state_d == RUN_ST) && (beat_d == BEAT_MAX);
      idle_q   <= (state_d == IDLE_ST);
      if (load_en) begin
        nburst_q <= NBURST_REG;
        burst_q  <= 32'h0;
        cycles_q <= 32'h0;
        cnt_q    <= DATA_WIDTH'(SEED_REG);
      end else begin
        if (run_en && (cycles_q != 32'hFFFF_FFFF)) begin
          cycles_q <= cycles_q + 32'd1;
        end
        if (accept) begin
          cnt_q <= cnt_q + DATA_WIDTH'(1);
          if (tlast_q) begin
            burst_q <= burst_q + 32'd1;
          end
        end
      end
    end
  end

`ifdef PATGEN_LFSR_EN
  logic        pattern_q;
  logic [31:0] lfsr_state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pattern_q <= 1'b0;
    end else if (load_en) begin
      pattern_q <= PATTERN_REG;
    end
  end

  patgen_lfsr32 u_lfsr (
    .clk     (clk),
    .rst     (rst),
    .load_i  (load_en),
    .seed_i  (SEED_REG),
    .adv_i   (accept),
    .state_o (lfsr_state)
  );

  assign m_axis_tdata = pattern_q ? {(DATA_WIDTH/32){lfsr_state}} : cnt_q;
`else
  assign m_axis_tdata = cnt_q;
`endif

  assign m_axis_tvalid = tvalid_q;
  assign m_axis_tlast  = tlast_q;
  assign m_axis_tstrb  = '1;
  assign IDLE_REG      = idle_q;
  assign CYCLES_REG    = cycles_q;

endmodule

// File: tb/tb_axis_pattern_gen.sv
// Directed bench for axis_pattern_gen: a 64-bit and a 32-bit instance share
// all inputs; LFSR scenario only when PATGEN_LFSR_EN is defined.
module tb_axis_pattern_gen;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        tready = 1'b1;
  logic        start = 1'b0;
  logic [31:0] nburst = 32'h0;
  logic [31:0] seed = 32'h0;
`ifdef PATGEN_LFSR_EN
  logic        pattern = 1'b0;
`endif

  logic        tvalid, tlast, idle;
  logic [63:0] tdata;
  logic [7:0]  tstrb;
  logic [31:0] cycles;
  logic        tvalid32, tlast32, idle32;
  logic [31:0] tdata32;
  logic [3:0]  tstrb32;
  logic [31:0] cycles32;

  int assertions = 0;
  int failures   = 0;

  logic [63:0] rec_d[$];
  logic [31:0] rec_d32[$];
  logic        rec_l[$];
  logic        rec_l32[$];
  int          first_valid;
  int          stall_viol;

  always #5 clk = ~clk;

  axis_pattern_gen #(.DATA_WIDTH(64), .BURST_LENGTH(7)) dut (
    .clk(clk), .rst(rst),
    .m_axis_tvalid(tvalid), .m_axis_tready(tready), .m_axis_tdata(tdata),
    .m_axis_tstrb(tstrb), .m_axis_tlast(tlast),
    .START_REG(start), .NBURST_REG(nburst), .SEED_REG(seed),
`ifdef PATGEN_LFSR_EN
    .PATTERN_REG(pattern),
`endif
    .IDLE_REG(idle), .CYCLES_REG(cycles)
  );

  axis_pattern_gen #(.DATA_WIDTH(32), .BURST_LENGTH(7)) dut32 (
    .clk(clk), .rst(rst),
    .m_axis_tvalid(tvalid32), .m_axis_tready(tready), .m_axis_tdata(tdata32),
    .m_axis_tstrb(tstrb32), .m_axis_tlast(tlast32),
    .START_REG(start), .NBURST_REG(nburst), .SEED_REG(seed),
`ifdef PATGEN_LFSR_EN
    .PATTERN_REG(pattern),
`endif
    .IDLE_REG(idle32), .CYCLES_REG(cycles32)
  );

  task automatic start_run(input logic [31:0] nb, input logic [31:0] sd);
    @(negedge clk);
    nburst = nb;
    seed   = sd;
    start  = 1'b1;
  endtask

  task automatic stop_run();
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
  endtask

  // Drives tready and records accepted beats; stall stability is tallied.
  task automatic collect(input int n, input bit toggle);
    int   phase = 0;
    int   guard = 0;
    bit   prev_stall = 1'b0;
    logic [63:0] prev_d = '0;
    logic prev_l = 1'b0;
    rec_d.delete(); rec_d32.delete(); rec_l.delete(); rec_l32.delete();
    first_valid = -1;
    stall_viol  = 0;
    while (rec_d.size() < n && guard < 400) begin
      @(negedge clk);
      guard++;
      if (tvalid) begin
        if (first_valid < 0) first_valid = guard;
        if (prev_stall && (tdata !== prev_d || tlast !== prev_l)) stall_viol++;
        tready = toggle ? (phase % 2 == 0) : 1'b1;
        phase++;
        if (tready) begin
          rec_d.push_back(tdata);
          rec_l.push_back(tlast);
          rec_d32.push_back(tdata32);
          rec_l32.push_back(tlast32);
        end
        prev_stall = !tready;
        prev_d = tdata;
        prev_l = tlast;
      end else begin
        if (prev_stall) stall_viol++;
        prev_stall = 1'b0;
        tready = 1'b1;
      end
    end
    @(negedge clk);
    tready = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    assertions++;
    if (tvalid !== 1'b0 || tlast !== 1'b0 || tdata !== 64'h0) begin
      failures++;
      $display("FAIL reset_stream: tvalid=%b tlast=%b tdata=%h, required 0 0 0", tvalid, tlast, tdata);
    end
    assertions++;
    if (idle !== 1'b1 || cycles !== 32'h0) begin
      failures++;
      $display("FAIL reset_regs: idle=%b cycles=%0d, required 1 0", idle, cycles);
    end
    rst = 1'b0;
    @(negedge clk);
    assertions++;
    if (tvalid !== 1'b0 || idle !== 1'b1) begin
      failures++;
      $display("FAIL reset_idle_after: tvalid=%b idle=%b, required 0 1", tvalid, idle);
    end
    $display("reset done");
  endtask

  task automatic test_counter_basic();
    start_run(32'd2, 32'h10);
    collect(16, 1'b0);
    assertions++;
    if (first_valid !== 2) begin
      failures++;
      $display("FAIL basic_latency: tvalid first seen %0d cycles after start, required 2", first_valid);
    end
    assertions++;
    if (rec_d.size() !== 16) begin
      failures++;
      $display("FAIL basic_count: %0d beats, required 16", rec_d.size());
    end
    for (int k = 0; k < rec_d.size(); k++) begin
      assertions++;
      if (rec_d[k] !== 64'h10 + 64'(k) || rec_l[k] !== (k % 8 == 7)) begin
        failures++;
        $display("FAIL basic_beat%0d: tdata=%h tlast=%b, required %h %b",
                 k, rec_d[k], rec_l[k], 64'h10 + 64'(k), (k % 8 == 7));
      end
    end
    assertions++;
    if (tvalid !== 1'b0 || cycles !== 32'd16 || idle !== 1'b0 || tstrb !== 8'hFF) begin
      failures++;
      $display("FAIL basic_end: tvalid=%b cycles=%0d idle=%b tstrb=%h, required 0 16 0 ff",
               tvalid, cycles, idle, tstrb);
    end
    repeat (3) @(negedge clk);
    assertions++;
    if (tvalid !== 1'b0 || idle !== 1'b0) begin
      failures++;
      $display("FAIL basic_no_restart: tvalid=%b idle=%b, required 0 0", tvalid, idle);
    end
    stop_run();
    assertions++;
    if (idle !== 1'b1 || cycles !== 32'd16) begin
      failures++;
      $display("FAIL basic_idle: idle=%b cycles=%0d, required 1 16", idle, cycles);
    end
    $display("counter run: %0d beats, cycles=%0d", rec_d.size(), cycles);
  endtask

  task automatic test_backpressure();
    start_run(32'd2, 32'h10);
    collect(16, 1'b1);
    assertions++;
    if (stall_viol !== 0) begin
      failures++;
      $display("FAIL bp_stable: %0d stall changes, required 0", stall_viol);
    end
    assertions++;
    if (rec_d.size() !== 16) begin
      failures++;
      $display("FAIL bp_count: %0d beats, required 16", rec_d.size());
    end
    for (int k = 0; k < rec_d.size(); k++) begin
      assertions++;
      if (rec_d[k] !== 64'h10 + 64'(k) || rec_l[k] !== (k % 8 == 7)) begin
        failures++;
        $display("FAIL bp_beat%0d: tdata=%h tlast=%b, required %h %b",
                 k, rec_d[k], rec_l[k], 64'h10 + 64'(k), (k % 8 == 7));
      end
    end
    assertions++;
    if (cycles !== 32'd31 || tvalid !== 1'b0) begin
      failures++;
      $display("FAIL bp_cycles: cycles=%0d tvalid=%b, required 31 0", cycles, tvalid);
    end
    stop_run();
    $display("backpressure run: %0d beats, cycles=%0d", rec_d.size(), cycles);
  endtask

  task automatic test_zero_burst();
    int seen = 0;
    start_run(32'd0, 32'h55);
    repeat (6) begin
      @(negedge clk);
      if (tvalid) seen++;
    end
    assertions++;
    if (seen !== 0) begin
      failures++;
      $display("FAIL zero_valid: tvalid high %0d cycles, required 0", seen);
    end
    assertions++;
    if (idle !== 1'b0 || cycles !== 32'd0) begin
      failures++;
      $display("FAIL zero_end: idle=%b cycles=%0d, required 0 0", idle, cycles);
    end
    stop_run();
    assertions++;
    if (idle !== 1'b1) begin
      failures++;
      $display("FAIL zero_idle: idle=%b, required 1", idle);
    end
    $display("zero-burst run: cycles=%0d", cycles);
  endtask

  task automatic test_counter_wrap();
    logic [31:0] exp32 [8] = '{32'hFFFFFFFE, 32'hFFFFFFFF, 32'h0, 32'h1,
                               32'h2, 32'h3, 32'h4, 32'h5};
    start_run(32'd1, 32'hFFFFFFFE);
    collect(8, 1'b0);
    assertions++;
    if (rec_d32.size() !== 8) begin
      failures++;
      $display("FAIL wrap_count: %0d beats, required 8", rec_d32.size());
    end
    for (int k = 0; k < rec_d32.size(); k++) begin
      assertions++;
      if (rec_d32[k] !== exp32[k] || rec_l32[k] !== (k == 7)) begin
        failures++;
        $display("FAIL wrap_beat%0d: tdata32=%h tlast=%b, required %h %b",
                 k, rec_d32[k], rec_l32[k], exp32[k], (k == 7));
      end
      assertions++;
      if (rec_d[k] !== 64'hFFFFFFFE + 64'(k)) begin
        failures++;
        $display("FAIL wrap64_beat%0d: tdata=%h, required %h", k, rec_d[k], 64'hFFFFFFFE + 64'(k));
      end
    end
    assertions++;
    if (cycles32 !== 32'd8 || tvalid32 !== 1'b0 || tstrb32 !== 4'hF) begin
      failures++;
      $display("FAIL wrap_end: cycles32=%0d tvalid32=%b tstrb32=%h, required 8 0 f",
               cycles32, tvalid32, tstrb32);
    end
    stop_run();
    assertions++;
    if (idle32 !== 1'b1) begin
      failures++;
      $display("FAIL wrap_idle: idle32=%b, required 1", idle32);
    end
    $display("wrap run: %0d beats, cycles32=%0d", rec_d32.size(), cycles32);
  endtask

`ifdef PATGEN_LFSR_EN
  task automatic test_lfsr();
    logic [31:0] hand [4] = '{32'h00000001, 32'h80200003, 32'hC0300002, 32'h60180001};
    logic [31:0] s;
    pattern = 1'b1;
    start_run(32'd1, 32'h0);
    collect(8, 1'b0);
    assertions++;
    if (rec_d.size() !== 8) begin
      failures++;
      $display("FAIL lfsr_count: %0d beats, required 8", rec_d.size());
    end
    s = hand[0];
    for (int k = 0; k < rec_d.size(); k++) begin
      if (k < 4) s = hand[k];
      else s = (s >> 1) ^ (s[0] ? 32'h80200003 : 32'h0);
      assertions++;
      if (rec_d[k] !== {s, s} || rec_d32[k] !== s) begin
        failures++;
        $display("FAIL lfsr_beat%0d: tdata=%h tdata32=%h, required %h %h",
                 k, rec_d[k], rec_d32[k], {s, s}, s);
      end
    end
    stop_run();
    pattern = 1'b0;
    $display("lfsr run: %0d beats", rec_d.size());
  endtask
`endif

  task automatic test_midrun_reset();
    start_run(32'd2, 32'h40);
    collect(5, 1'b0);
    rst = 1'b1;
    #1;
    assertions++;
    if (tvalid !== 1'b0 || tlast !== 1'b0 || tdata !== 64'h0 || idle !== 1'b1 || cycles !== 32'h0) begin
      failures++;
      $display("FAIL midrst_async: tvalid=%b tlast=%b tdata=%h idle=%b cycles=%0d, required 0 0 0 1 0",
               tvalid, tlast, tdata, idle, cycles);
    end
    @(negedge clk);
    rst = 1'b0;
    collect(16, 1'b0);
    assertions++;
    if (rec_d.size() !== 16 || first_valid !== 2) begin
      failures++;
      $display("FAIL midrst_restart: %0d beats latency %0d, required 16 2", rec_d.size(), first_valid);
    end
    for (int k = 0; k < rec_d.size(); k++) begin
      assertions++;
      if (rec_d[k] !== 64'h40 + 64'(k) || rec_l[k] !== (k % 8 == 7)) begin
        failures++;
        $display("FAIL midrst_beat%0d: tdata=%h tlast=%b, required %h %b",
                 k, rec_d[k], rec_l[k], 64'h40 + 64'(k), (k % 8 == 7));
      end
    end
    assertions++;
    if (cycles !== 32'd16) begin
      failures++;
      $display("FAIL midrst_cycles: cycles=%0d, required 16", cycles);
    end
    stop_run();
    $display("mid-run reset: restarted run %0d beats, cycles=%0d", rec_d.size(), cycles);
  endtask

  initial begin
    test_reset();
    test_counter_basic();
    test_backpressure();
    test_zero_burst();
    test_counter_wrap();
`ifdef PATGEN_LFSR_EN
    test_lfsr();
`endif
    test_midrun_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

endmodule
